// File: rtl/serial_pkg.sv
// Shared types, parity-mode constants and the parity helper for the serial receiver.
package serial_pkg;

  // Data width assumed by the parity helper; the receiver is built for 8-bit frames.
  localparam int unsigned DataW = 8;

  // Parity handling modes.
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Receiver frame states.
  typedef enum logic [1:0] {
    StIdle,
    StData,
    StPar,
    StStop
  } rx_state_e;

  // Expected parity bit for a data byte: XOR of the data, inverted for odd parity.
  function automatic logic calc_parity(input logic [DataW-1:0] data, input int unsigned mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/rx_fifo2.sv
// Two-entry output buffer. A pop and a push on the same edge both take effect,
// including when the buffer is full.
module rx_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is accepted only when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Buffer state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: start bit, DW data bits LSB first, optional parity, stop bit.
// Received bytes go through a 2-entry buffer; errors are reported as one-cycle pulses.
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned PAR_MODE = PAR_NONE,
  parameter int unsigned DW       = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          SIN,
  input  logic          BEN,
  output logic [DW-1:0] DOUT,
  output logic          VALID,
  input  logic          READY,
  output logic          FERR,
  output logic          PERR,
  output logic          OVR
);

  localparam int unsigned CntW = $clog2(DW);

  rx_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          perr_lat_q, perr_lat_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign VALID = ~fifo_empty;
  assign pop   = VALID & READY;
  assign FERR  = ferr_q;
  assign PERR  = perr_q;
  assign OVR   = ovr_q;

  // Frame FSM next-state, data shifter and error pulse generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    perr_lat_d = perr_lat_q;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    push       = 1'b0;
    if (BEN) begin
      unique case (state_q)
        StIdle: begin
          if (!SIN) begin
            state_d    = StData;
            cnt_d      = '0;
            perr_lat_d = 1'b0;
          end
        end
        StData: begin
          shift_d[cnt_q] = SIN;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == CntW'(DW - 1)) begin
            state_d = (PAR_MODE != PAR_NONE) ? StPar : StStop;
          end
        end
        StPar: begin
          perr_lat_d = (SIN != calc_parity(shift_q, PAR_MODE));
          state_d    = StStop;
        end
        StStop: begin
          // A low stop bit is a framing error, never a new start bit.
          state_d = StIdle;
          if (SIN) begin
            if (perr_lat_q) perr_d = 1'b1;
            else            push   = 1'b1;
          end else begin
            ferr_d = 1'b1;
            perr_d = perr_lat_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // Overrun only when the buffer is full and nothing leaves on this edge.
    ovr_d = push & fifo_full & ~pop;
  end

  // Frame state and pulse registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      perr_lat_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      perr_lat_q <= perr_lat_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  rx_fifo2 #(
    .Width (DW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (DOUT)
  );

endmodule
